// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader: serial loader for the daisy-chained GPIO configuration blocks.
//
// Walks the config register array from the highest pad down to pad 0, shifting
// each CFG_BITS-wide word MSB first onto loader_data with loader_clock toggling
// every half-period, then pulses loader_strobe and signals done.
//
// Ports:
//   clk, reset      system clock and synchronous active-high reset
//   start, abort    single-cycle load / clear requests (abort wins)
//   busy, done      sequence in progress / one-cycle load-complete pulse
//   cfg_rd_idx      pad index presented to the config array
//   cfg_rd_data     combinational config word for cfg_rd_idx
//   div_sel         runtime half-period (only with GPIO_LOADER_RUNTIME_DIV_EN;
//                   0 selects CLK_DIV, sampled when start/abort is accepted)
//   loader_*        chain reset (active-low), shift clock, serial data, strobe
//
// Optional feature macro: GPIO_LOADER_RUNTIME_DIV_EN.
module gpio_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4,
  parameter int IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    cfg_rd_idx,
  input  logic [CFG_BITS-1:0] cfg_rd_data,
`ifdef GPIO_LOADER_RUNTIME_DIV_EN
  input  logic [7:0]          div_sel,
`endif
  output logic                loader_resetn,
  output logic                loader_clock,
  output logic                loader_data,
  output logic                loader_strobe
);
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
`ifdef GPIO_LOADER_RUNTIME_DIV_EN
  localparam int DW = ($clog2(CLK_DIV + 1) > 8) ? $clog2(CLK_DIV + 1) : 8;
`else
  localparam int DW = $clog2(CLK_DIV + 1);
`endif

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, STROBE, CLEAR, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDX_W-1:0] pad_q, pad_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic [DW-1:0]   hp_q, hp_d;
  logic [DW-1:0]   hp_new;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            resetn_q, resetn_d;
  logic            clock_q, clock_d;
  logic            data_q, data_d;
  logic            strobe_q, strobe_d;
  logic            expired;

  // The half-period is latched on acceptance so later div_sel changes are inert.
`ifdef GPIO_LOADER_RUNTIME_DIV_EN
  assign hp_new = (div_sel == 8'd0) ? DW'(CLK_DIV) : DW'(div_sel);
`else
  assign hp_new = DW'(CLK_DIV);
`endif

  assign expired = (div_q == '0);

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    div_d   = div_q;
    hp_d    = hp_q;
    if (abort) begin
      state_d = CLEAR;
      div_d   = hp_new - 1'b1;
      hp_d    = hp_new;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = SETUP;
          pad_d   = IDX_W'(NUM_PADS - 1);
          bit_d   = BW'(CFG_BITS - 1);
          div_d   = hp_new - 1'b1;
          hp_d    = hp_new;
        end
        SETUP: begin
          div_d   = expired ? hp_q - 1'b1 : div_q - 1'b1;
          state_d = expired ? HIGH : SETUP;
        end
        HIGH: begin
          div_d = expired ? hp_q - 1'b1 : div_q - 1'b1;
          if (expired) begin
            // Pad 0 bit 0 is the final bit; the index stays put rather than wrapping.
            state_d = (bit_q == '0 && pad_q == '0) ? STROBE : SETUP;
            bit_d   = (bit_q == '0) ? BW'(CFG_BITS - 1) : bit_q - 1'b1;
            pad_d   = (bit_q == '0 && pad_q != '0) ? pad_q - 1'b1 : pad_q;
          end
        end
        STROBE: begin
          div_d   = expired ? hp_q - 1'b1 : div_q - 1'b1;
          state_d = expired ? DONE : STROBE;
        end
        CLEAR: begin
          div_d   = expired ? hp_q - 1'b1 : div_q - 1'b1;
          state_d = expired ? IDLE : CLEAR;
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are registered images of the next state.
    busy_d   = (state_d != IDLE) && (state_d != DONE);
    done_d   = (state_d == DONE);
    resetn_d = (state_d != CLEAR);
    clock_d  = (state_d == HIGH);
    strobe_d = (state_d == STROBE);
    // Data is captured throughout SETUP so it is settled before the rising edge.
    data_d   = (state_d == CLEAR) ? 1'b0 : (state_q == SETUP) ? cfg_rd_data[bit_q] : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pad_q    <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      hp_q     <= DW'(CLK_DIV);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resetn_q <= 1'b1;
      clock_q  <= 1'b0;
      data_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      hp_q     <= hp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resetn_q <= resetn_d;
      clock_q  <= clock_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_rd_idx    = pad_q;
  assign loader_resetn = resetn_q;
  assign loader_clock  = clock_q;
  assign loader_data   = data_q;
  assign loader_strobe = strobe_q;
endmodule

// File: tb/tb_gpio_cfg_loader.sv
// tb_gpio_cfg_loader: directed self-checking bench for gpio_cfg_loader.
module tb_gpio_cfg_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, loader_resetn, loader_clock, loader_data, loader_strobe;
  logic [0:0] cfg_rd_idx;
  logic [2:0] cfg_rd_data;
`ifdef GPIO_LOADER_RUNTIME_DIV_EN
  logic [7:0] div_sel = 8'd0;
`endif

  assign cfg_rd_data = (cfg_rd_idx == 1'b1) ? 3'b101 : 3'b011;

  gpio_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .cfg_rd_idx(cfg_rd_idx), .cfg_rd_data(cfg_rd_data),
`ifdef GPIO_LOADER_RUNTIME_DIV_EN
    .div_sel(div_sel),
`endif
    .loader_resetn(loader_resetn), .loader_clock(loader_clock),
    .loader_data(loader_data), .loader_strobe(loader_strobe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] n;
    logic [6:0] exp;
  } row_t;

  row_t rows [12];
  int pass_cnt = 0, total = 0;
  int cyc = 0, edges = 0, strobe_cnt = 0, done_cnt = 0, done_cyc = -1;
  logic [15:0] bits = '0;
  logic prev_clk = 1'b0;

  function automatic logic [6:0] outs();
    return {busy, loader_clock, loader_data, loader_strobe, done, loader_resetn, cfg_rd_idx};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (loader_clock && !prev_clk) begin
      bits = {bits[14:0], loader_data};
      edges++;
    end
    prev_clk = loader_clock;
    if (loader_strobe) strobe_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clr();
    cyc = 0; edges = 0; strobe_cnt = 0; done_cnt = 0; done_cyc = -1; bits = '0;
    prev_clk = loader_clock;
  endtask

  task automatic launch();
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk_load(input string name, input int done_at);
    chk({name, " edges"}, 16'(edges), 16'd6);
    chk({name, " bits"}, bits, 16'b101011);
    chk({name, " strobe_cycles"}, 16'(strobe_cnt), 16'd2);
    chk({name, " done_count"}, 16'(done_cnt), 16'd1);
    chk({name, " done_cycle"}, 16'(done_cyc), 16'(done_at));
  endtask

  initial begin
    // n, {busy, clock, data, strobe, done, resetn, idx}
    rows[0]  = '{8'd2,  7'b1010011};
    rows[1]  = '{8'd3,  7'b1110011};
    rows[2]  = '{8'd6,  7'b1000011};
    rows[3]  = '{8'd7,  7'b1100011};
    rows[4]  = '{8'd11, 7'b1110011};
    rows[5]  = '{8'd13, 7'b1010010};
    rows[6]  = '{8'd15, 7'b1100010};
    rows[7]  = '{8'd19, 7'b1110010};
    rows[8]  = '{8'd23, 7'b1110010};
    rows[9]  = '{8'd25, 7'b1011010};
    rows[10] = '{8'd27, 7'b0010110};
    rows[11] = '{8'd28, 7'b0010010};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", 16'(outs()), 16'b0000010);

    launch();
    for (int i = 0; i < 12; i++) begin
      run_to(int'(rows[i].n));
      chk($sformatf("table_cycle_%0d", rows[i].n), 16'(outs()), 16'(rows[i].exp));
    end
    run_to(32);
    chk_load("basic", 27);

    launch();
    run_to(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(32);
    chk_load("busy_start", 27);

    launch();
    run_to(9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_c10", 16'(outs() >> 1), 16'b100000);
    tick();
    chk("abort_c11", 16'(outs() >> 1), 16'b100000);
    tick();
    chk("abort_c12", 16'(outs() >> 1), 16'b000001);
    run_to(40);
    chk("abort_no_strobe", 16'(strobe_cnt), 16'd0);
    chk("abort_no_done", 16'(done_cnt), 16'd0);
    launch();
    run_to(32);
    chk_load("after_abort", 27);

    clr();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_prio", 16'({busy, loader_resetn, loader_clock}), 16'b100);
    run_to(10);
    chk("abort_prio_idle", 16'({busy, loader_resetn, edges[0]}), 16'b010);
    chk("abort_prio_no_done", 16'(done_cnt), 16'd0);

    launch();
    run_to(28);
    chk("b2b_first_done", 16'(done_cyc), 16'd27);
    launch();
    run_to(32);
    chk_load("b2b_second", 27);

    launch();
    run_to(15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_outputs", 16'(outs()), 16'b0000010);
    run_to(50);
    chk("midreset_no_strobe", 16'(strobe_cnt), 16'd0);
    chk("midreset_no_done", 16'(done_cnt), 16'd0);

`ifdef GPIO_LOADER_RUNTIME_DIV_EN
    div_sel = 8'd5;
    launch();
    run_to(70);
    chk("rtdiv5_done_cycle", 16'(done_cyc), 16'd66);
    chk("rtdiv5_bits", bits, 16'b101011);
    chk("rtdiv5_strobe", 16'(strobe_cnt), 16'd5);
    div_sel = 8'd0;
    launch();
    div_sel = 8'd7;
    run_to(32);
    div_sel = 8'd0;
    chk_load("rtdiv0", 27);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
